// File: rtl/pad_display_controller.sv
// -----------------------------------------------------------------------------
// pad_display_controller
//
// Purpose:
//   Simon pad renderer. Produces the registered 12-bit VGA pixel colour for a
//   rectangular pad window plus a button-driven background. A small flash
//   sequencer accepts a pad index from the game FSM (valid/ready), lights that
//   pad for FLASH_TICKS frame ticks, blanks it for GAP_TICKS ticks, then pulses
//   flash_done for one clock.
//
// Ports:
//   clk         in   system/pixel clock, rising edge
//   rst         in   asynchronous active-high reset
//   tick        in   one-clock frame strobe; qualifies all timing and bg updates
//   bright      in   high inside the visible area
//   hCount      in   [9:0] horizontal pixel counter
//   vCount      in   [9:0] vertical line counter
//   img_color   in   [11:0] idle pad artwork from image ROM
//   show_valid  in   request to flash pad show_idx
//   show_idx    in   [IDX_W-1:0] pad to flash (1..NUM_PADS, others dropped)
//   show_ready  out  high when a request can be accepted (IDLE)
//   btn         in   [NUM_PADS-1:0] player buttons, bit i = pad i+1
//   busy        out  high in FLASH or GAP
//   flash_done  out  one-clock pulse in the first IDLE cycle after a sequence
//   rgb         out  [11:0] registered pixel colour
//   background  out  [11:0] registered background colour
// -----------------------------------------------------------------------------
module pad_display_controller #(
    parameter int          NUM_PADS    = 4,
    parameter int          IDX_W       = 3,
    parameter int          BLK_X0      = 144,
    parameter int          BLK_Y0      = 35,
    parameter int          BLK_W       = 640,
    parameter int          BLK_H       = 480,
    parameter int          FLASH_TICKS = 30,
    parameter int          GAP_TICKS   = 10,
    parameter int          CNT_W       = 8,
    parameter logic [11:0] BG_RESET    = 12'hFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                bright,
    input  logic [9:0]          hCount,
    input  logic [9:0]          vCount,
    input  logic [11:0]         img_color,
    input  logic                show_valid,
    input  logic [IDX_W-1:0]    show_idx,
    output logic                show_ready,
    input  logic [NUM_PADS-1:0] btn,
    output logic                busy,
    output logic                flash_done,
    output logic [11:0]         rgb,
    output logic [11:0]         background
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLASH = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_TICKS);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W:0]   MAX_IDX  = (IDX_W+1)'(NUM_PADS);

    // Window bounds widened to 11 bits so an edge at 1023 cannot wrap.
    localparam logic [10:0] X_LO = 11'(BLK_X0);
    localparam logic [10:0] X_HI = 11'(BLK_X0 + BLK_W - 1);
    localparam logic [10:0] Y_LO = 11'(BLK_Y0);
    localparam logic [10:0] Y_HI = 11'(BLK_Y0 + BLK_H - 1);

    function automatic logic [11:0] pad_color(input logic [3:0] idx);
        case (idx)
            4'd1:    pad_color = 12'hF00;
            4'd2:    pad_color = 12'h01F;
            4'd3:    pad_color = 12'hFF0;
            4'd4:    pad_color = 12'h0F0;
            4'd5:    pad_color = 12'hF0F;
            4'd6:    pad_color = 12'h0FF;
            4'd7:    pad_color = 12'hF80;
            4'd8:    pad_color = 12'hFFF;
            default: pad_color = 12'h000;
        endcase
    endfunction

    // Lowest-numbered pressed button wins: scan from the top down so the
    // last assignment is the lowest index.
    function automatic logic [11:0] btn_color(input logic [NUM_PADS-1:0] b);
        logic [11:0] c;
        c = 12'h000;
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (b[i]) c = pad_color(4'(i + 1));
        end
        return c;
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_cur_idx;
    logic               r_flash_done;
    logic [11:0]        r_rgb;
    logic [11:0]        r_background;

    state_t             w_next_state;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_next_done;
    logic               w_idx_ok;
    logic               w_in_blk;
    logic [10:0]        w_h;
    logic [10:0]        w_v;

    assign show_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign flash_done = r_flash_done;
    assign rgb        = r_rgb;
    assign background = r_background;

    assign w_idx_ok = (show_idx != '0) && ({1'b0, show_idx} <= MAX_IDX);

    assign w_h      = {1'b0, hCount};
    assign w_v      = {1'b0, vCount};
    assign w_in_blk = (w_h >= X_LO) && (w_h <= X_HI) &&
                      (w_v >= Y_LO) && (w_v <= Y_HI);

    // Flash sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cur_idx    <= '0;
            r_flash_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_cur_idx    <= w_next_idx;
            r_flash_done <= w_next_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_idx   = r_cur_idx;
        w_next_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Out-of-range indices are consumed (ready is high) but dropped.
                // A tick coinciding with acceptance is not counted.
                if (show_valid && w_idx_ok) begin
                    w_next_idx   = show_idx;
                    w_next_cnt   = FLASH_LD;
                    w_next_state = S_FLASH;
                end
            end
            S_FLASH: begin
                if (tick) begin
                    if (r_cnt <= CNT_ONE) begin
                        if (GAP_TICKS > 0) begin
                            w_next_cnt   = GAP_LD;
                            w_next_state = S_GAP;
                        end else begin
                            w_next_cnt   = '0;
                            w_next_state = S_IDLE;
                            w_next_done  = 1'b1;
                        end
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (r_cnt <= CNT_ONE) begin
                        w_next_cnt   = '0;
                        w_next_state = S_IDLE;
                        w_next_done  = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Pixel colour and background registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb        <= 12'h000;
            r_background <= BG_RESET;
        end else begin
            if (!bright)
                r_rgb <= 12'h000;
            else if (w_in_blk && r_state == S_FLASH)
                r_rgb <= pad_color(4'(r_cur_idx));
            else if (w_in_blk && r_state == S_GAP)
                r_rgb <= 12'h000;
            else if (w_in_blk)
                r_rgb <= img_color;
            else
                r_rgb <= r_background;

            if (tick)
                r_background <= btn_color(btn);
        end
    end

endmodule

// File: doc/pad_display_controller.md
Name: pad_display_controller

Overview:
Parametrised Simon pad renderer. Drives the 12-bit VGA pixel colour for a configurable rectangular pad window and a button-driven background. Adds a flash sequencer: the game FSM hands it a pad index over a valid/ready handshake, and the block lights that pad for a fixed number of frame ticks, then blanks it for a gap. It sits between the game FSM and the display timing controller, with the image ROM feeding the idle pad artwork.

Parameters:
NUM_PADS, 4, number of pads/buttons (1..8); pad indices 1..NUM_PADS, index 0 = none
IDX_W, 3, width of show_idx
BLK_X0, 144, left edge of pad window in hCount units, inclusive
BLK_Y0, 35, top edge of pad window in vCount units, inclusive
BLK_W, 640, pad window width in pixels (>=1)
BLK_H, 480, pad window height in pixels (>=1)
FLASH_TICKS, 30, tick pulses the pad stays lit (>=1)
GAP_TICKS, 10, tick pulses of dark gap after a flash (0 = no gap)
CNT_W, 8, width of the tick counter; must hold max(FLASH_TICKS, GAP_TICKS)
BG_RESET, 12'hFFF, background value on reset

Ports:
clk  input  1  single system/pixel clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
tick  input  1  one-clk frame-rate strobe; all timing and background updates are qualified by it
bright  input  1  high inside the visible display area
hCount  input  10  horizontal pixel counter
vCount  input  10  vertical line counter
img_color  input  12  idle pad artwork from image ROM
show_valid  input  1  request to flash pad show_idx
show_idx  input  IDX_W  pad to flash
show_ready  output  1  high when a request can be accepted
btn  input  NUM_PADS  player buttons; bit i = pad i+1
busy  output  1  high in FLASH or GAP
flash_done  output  1  one-clk pulse when a flash+gap sequence completes
rgb  output  12  registered pixel colour
background  output  12  registered current background colour

Behaviour:
- Palette, indices 1..8: F00 red, 01F blue, FF0 yellow, 0F0 green, F0F, 0FF, F80, FFF.
- Reset (async, any state): FSM=IDLE, counter=0, cur_idx=0, rgb=000, background=BG_RESET, flash_done=0, busy=0.
- FSM states: IDLE, FLASH, GAP.
- show_ready = (state==IDLE); busy = (state!=IDLE). Both are combinational from state.
- IDLE:
  - Handshake fires when show_valid && show_ready.
  - If show_idx is in 1..NUM_PADS: latch cur_idx, load counter=FLASH_TICKS, go to FLASH.
  - Otherwise: the request is consumed and dropped; stay IDLE; no flash_done.
  - A tick in the acceptance cycle is not counted.
- FLASH: on tick, decrement the counter. On the tick that takes it from 1:
  - GAP_TICKS>0: go to GAP with counter=GAP_TICKS.
  - GAP_TICKS==0: go to IDLE and pulse flash_done.
- GAP: on tick, decrement. On the tick that takes it from 1, go to IDLE and pulse flash_done.
- flash_done is registered and high for exactly one clk, in the first IDLE cycle. A new request may be accepted in that same cycle.
- show_valid is ignored while busy. It must be held by the source until accepted.
- Pad window: in_blk = hCount in [BLK_X0, BLK_X0+BLK_W-1] and vCount in [BLK_Y0, BLK_Y0+BLK_H-1]. Both bounds inclusive; compare in 11 bits so edges up to 1023 do not wrap.
- rgb is registered, 1 clk after hCount/vCount/bright. Priority:
  1. ~bright -> 000
  2. in_blk && FLASH -> palette[cur_idx]
  3. in_blk && GAP -> 000
  4. in_blk && IDLE -> img_color
  5. otherwise -> background
- background updates only on tick:
  - Lowest-numbered pressed button wins -> its palette colour.
  - No button pressed -> 000.
  - Between ticks it holds its value. Button changes without a tick have no effect.
- Buttons have no effect on the FSM.

Test Plan:
- Reset released, bright=1, hCount=200, vCount=100, img_color=ABC, no tick -> rgb=ABC one clk later; background=FFF; show_ready=1.
- Pulse show_valid with show_idx=2, FLASH_TICKS=3, GAP_TICKS=2 -> in-window rgb=01F for exactly 3 ticks, then 000 for 2 ticks, then flash_done for 1 clk and rgb=img_color; busy high throughout the flash and gap.
- show_idx=0 and show_idx=5 (NUM_PADS=4) -> request consumed, busy stays 0, no flash_done, rgb=img_color.
- btn=4'b1010 with a tick -> background=01F; drop to 4'b0000 without a tick -> stays 01F; next tick -> 000. Pixel at hCount=100 (outside window) shows background.
- Window edges with BLK_X0=144, BLK_W=640: hCount 143 -> background; 144 and 783 -> pad colour; 784 -> background. bright=0 anywhere -> 000.
- Assert rst mid-FLASH -> immediate IDLE, rgb=000, background=FFF, no flash_done; a fresh request is accepted after release.
